// File: rtl/regfile_multiport_sb_pkg.sv
// ---------------------------------------------------------------------------
// pkg_regfile_mp
// Shared constants, types and helpers for the multi-port register file with
// a pending-write scoreboard.
//   DEF_DATA_W / DEF_NUM_REGS / DEF_PEND_W : default parameter values
//   t_reg_sel / t_reg_data                 : register select / data types at
//                                            the default sizes
//   t_rd_src / bypass_pick()               : read-source priority used by
//                                            every read port's bypass mux
// ---------------------------------------------------------------------------
package pkg_regfile_mp;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_PEND_W   = 2;
    localparam int DEF_SEL_W    = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_SEL_W-1:0]  t_reg_sel;
    typedef logic [DEF_DATA_W-1:0] t_reg_data;

    // Where a read port takes its data from this cycle.
    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WR0   = 2'd1,
        SRC_WR1   = 2'd2
    } t_rd_src;

    // Load return (port 1) overrides ALU writeback (port 0), which overrides
    // the stored value. The result selects the data, so this stays width
    // agnostic for any DATA_W.
    function automatic t_rd_src bypass_pick(input logic hit0, input logic hit1);
        if (hit1) begin
            return SRC_WR1;
        end
        if (hit0) begin
            return SRC_WR0;
        end
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_multiport_sb_pend_counter.sv
// ---------------------------------------------------------------------------
// regfile_pend_counter
// Saturating up/down counter tracking the writes still outstanding for one
// register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   inc          : reservation request (ignored while at_max)
//   dec0, dec1   : write port 0 / port 1 landing on this register
//   cnt          : current outstanding-write count
//   at_max       : count is saturated, a reservation would be refused
// ---------------------------------------------------------------------------
module regfile_pend_counter
    import pkg_regfile_mp::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec0,
    input  logic              dec1,
    output logic [PEND_W-1:0] cnt,
    output logic              at_max
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic [PEND_W:0]   up;
    logic [PEND_W:0]   down;

    assign at_max = &cnt_q;
    assign cnt    = cnt_q;

    // The increment is gated by the pre-write count, then the net delta is
    // applied and floored at zero. A granted increment never pushes past the
    // maximum, so the result always fits in PEND_W bits.
    assign up   = {1'b0, cnt_q} + (PEND_W+1)'(inc & ~at_max);
    assign down = (PEND_W+1)'(dec0) + (PEND_W+1)'(dec1);

    always_comb begin
        cnt_d = '0;
        if (up > down) begin
            cnt_d = PEND_W'(up - down);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_multiport_sb.sv
// ---------------------------------------------------------------------------
// regfile_multiport_sb
// Parametrised register file with NUM_RD read ports, two write ports and a
// per-register pending-write scoreboard for RAW hazard detection at issue.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rd_sel      : NUM_RD packed read selects, port i at [i*SEL_W +: SEL_W]
//   rd_data     : NUM_RD packed read data, same packing
//   rd_pend     : selected register still has outstanding writes
//   wr_en       : [0] ALU writeback, [1] load return
//   wr_sel      : packed write selects (port 0 low)
//   wr_data     : packed write data (port 0 low)
//   rsv_en      : reserve rsv_sel (increment its pending count)
//   rsv_sel     : register to reserve
//   rsv_stall   : reservation refused, counter saturated
// Build option: define REGFILE_SYNC_READ_EN to register rd_data/rd_pend at
// posedge clk (one-cycle read latency); by default reads are combinational.
// Register 0 reads as zero, is never pending and ignores writes/reservations.
// ---------------------------------------------------------------------------
module regfile_multiport_sb
    import pkg_regfile_mp::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int NUM_RD   = 5,
    parameter int PEND_W   = DEF_PEND_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [1:0]               wr_en,
    input  logic [2*SEL_W-1:0]       wr_sel,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic                     rsv_en,
    input  logic [SEL_W-1:0]         rsv_sel,
    output logic                     rsv_stall
);

    logic [SEL_W-1:0]  wsel0;
    logic [SEL_W-1:0]  wsel1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              wr0_ok;
    logic              wr1_ok;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] at_max;
    logic [NUM_REGS-1:0] pend_vis;

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_pend_c;

    assign wsel0  = wr_sel[0 +: SEL_W];
    assign wsel1  = wr_sel[SEL_W +: SEL_W];
    assign wdata0 = wr_data[0 +: DATA_W];
    assign wdata1 = wr_data[DATA_W +: DATA_W];

    // Writes aimed at register 0 are dropped everywhere, including bypass.
    assign wr0_ok = wr_en[0] && (wsel0 != '0);
    assign wr1_ok = wr_en[1] && (wsel1 != '0);

    // Port 1 is applied last so it wins a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs[wsel0] <= wdata0;
            end
            if (wr1_ok) begin
                regs[wsel1] <= wdata1;
            end
        end
    end

    // Register 0 has no counter: never pending, never saturated, so a
    // reservation of it neither counts nor stalls.
    assign at_max[0]   = 1'b0;
    assign pend_vis[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
        logic              inc;
        logic              dec0;
        logic              dec1;
        logic [PEND_W-1:0] cnt;

        assign inc  = rsv_en && (rsv_sel == SEL_W'(r));
        assign dec0 = wr_en[0] && (wsel0 == SEL_W'(r));
        assign dec1 = wr_en[1] && (wsel1 == SEL_W'(r));

        regfile_pend_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (inc),
            .dec0   (dec0),
            .dec1   (dec1),
            .cnt    (cnt),
            .at_max (at_max[r])
        );

        // Pending as seen by readers: after this cycle's write credit, before
        // this cycle's reservation, so a final landing write clears it now.
        assign pend_vis[r] = ({1'b0, cnt} > ((PEND_W+1)'(dec0) + (PEND_W+1)'(dec1)));
    end

    assign rsv_stall = rsv_en && at_max[rsv_sel];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [SEL_W-1:0] sel;
        t_rd_src          src;

        assign sel = rd_sel[i*SEL_W +: SEL_W];
        assign src = bypass_pick(wr0_ok && (wsel0 == sel), wr1_ok && (wsel1 == sel));

        assign rd_data_c[i*DATA_W +: DATA_W] = (sel == '0)       ? '0     :
                                               (src == SRC_WR1)  ? wdata1 :
                                               (src == SRC_WR0)  ? wdata0 :
                                                                   regs[sel];
        assign rd_pend_c[i] = pend_vis[sel];
    end

`ifdef REGFILE_SYNC_READ_EN
    // Register-read stage: capture the bypassed view at the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_pend <= '0;
        end else begin
            rd_data <= rd_data_c;
            rd_pend <= rd_pend_c;
        end
    end
`else
    assign rd_data = rd_data_c;
    assign rd_pend = rd_pend_c;
`endif

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport_sb
// Self-checking bench for regfile_multiport_sb at default parameters.
// Expected read results are queued when a cycle's stimulus is driven and
// popped when the DUT output for that cycle is valid (same cycle for
// combinational reads, after the edge when REGFILE_SYNC_READ_EN is defined).
// ---------------------------------------------------------------------------
module tb_regfile_multiport_sb;

    localparam int DW   = 32;
    localparam int NR   = 16;
    localparam int SW   = 4;
    localparam int NRD  = 5;
    localparam int MAXP = 3;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        pend;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NRD*SW-1:0] rd_sel;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_pend;
    logic [1:0]        wr_en;
    logic [2*SW-1:0]   wr_sel;
    logic [2*DW-1:0]   wr_data;
    logic              rsv_en;
    logic [SW-1:0]     rsv_sel;
    logic              rsv_stall;

    int          errors;
    int          checks;
    exp_t        q[$];
    exp_t        e;
    logic [31:0] got_d;
    logic        got_p;
    logic        exp_s;
    logic [31:0] mregs [NR];
    int          mpend [NR];

    regfile_multiport_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_pend   (rd_pend),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_sel   (rsv_sel),
        .rsv_stall (rsv_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_dec(int s);
        int d;
        d = 0;
        if (wr_en[0] && wr_sel[3:0] == s) d++;
        if (wr_en[1] && wr_sel[7:4] == s) d++;
        return d;
    endfunction

    function automatic logic [31:0] m_data(int s);
        if (s == 0) return 32'h0;
        if (wr_en[1] && wr_sel[7:4] == s) return wr_data[63:32];
        if (wr_en[0] && wr_sel[3:0] == s) return wr_data[31:0];
        return mregs[s];
    endfunction

    function automatic logic m_pend(int s);
        if (s == 0) return 1'b0;
        return (mpend[s] - m_dec(s)) > 0;
    endfunction

    function automatic logic m_stall();
        return rsv_en && (rsv_sel != 0) && (mpend[rsv_sel] == MAXP);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            mregs[r] = 32'h0;
            mpend[r] = 0;
        end
    endtask

    task automatic model_update();
        logic inc_ok;
        int   v;
        inc_ok = rsv_en && (rsv_sel != 0) && (mpend[rsv_sel] < MAXP);
        for (int r = 1; r < NR; r++) begin
            v = mpend[r] - m_dec(r) + ((inc_ok && rsv_sel == r) ? 1 : 0);
            mpend[r] = (v < 0) ? 0 : v;
        end
        if (wr_en[0] && wr_sel[3:0] != 0) mregs[wr_sel[3:0]] = wr_data[31:0];
        if (wr_en[1] && wr_sel[7:4] != 0) mregs[wr_sel[7:4]] = wr_data[63:32];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        wr_en   = 2'b00;
        wr_sel  = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_sel = '0;
        rd_sel  = '0;
    endtask

    task automatic set_rd(input int p, input int s);
        rd_sel[p*SW +: SW] = SW'(s);
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input logic pd);
        exp_t x;
        x.port = p;
        x.data = d;
        x.pend = pd;
        q.push_back(x);
    endtask

    task automatic push_model_all();
        for (int p = 0; p < NRD; p++) begin
            push_exp(p, m_data(int'(rd_sel[p*SW +: SW])), m_pend(int'(rd_sel[p*SW +: SW])));
        end
    endtask

    // Called 1 time unit after driving at negedge; returns when this cycle's
    // read result is observable.
    task automatic wait_output();
`ifdef REGFILE_SYNC_READ_EN
        @(posedge clk);
        model_update();
        #1;
`else
        #3;
`endif
    endtask

    task automatic finish_cycle();
`ifndef REGFILE_SYNC_READ_EN
        @(posedge clk);
        model_update();
`endif
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rsv_en  = 1'b1;
        rsv_sel = 4'd5;
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) set_rd(p, g*4 + p);
            #1;
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (rd_data[p*DW +: DW] !== 32'h0 || rd_pend[p] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_read r%0d: data=%h pend=%b, expected data=0 pend=0",
                             g*4 + p, rd_data[p*DW +: DW], rd_pend[p]);
                end
            end
        end
        checks++;
        if (rsv_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall: stall=%b, expected 0", rsv_stall);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Reset pulled while a write and a reservation of r4 are in flight.
        @(negedge clk);
        wr_en        = 2'b01;
        wr_sel[3:0]  = 4'd4;
        wr_data[31:0] = 32'hCAFE_F00D;
        rsv_en       = 1'b1;
        rsv_sel      = 4'd4;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        set_rd(0, 4);
        push_exp(0, 32'h0, 1'b0);
        #1;
        wait_output();
        while (q.size() != 0) begin
            e = q.pop_front();
            got_d = rd_data[e.port*DW +: DW];
            got_p = rd_pend[e.port];
            checks++;
            if (got_d !== e.data || got_p !== e.pend) begin
                errors++;
                $display("[TB] FAIL reset_midwrite port%0d: data=%h pend=%b, expected data=%h pend=%b",
                         e.port, got_d, got_p, e.data, e.pend);
            end
        end
        finish_cycle();
    endtask

    task automatic test_dual_write();
        for (int c = 0; c < 2; c++) begin
            drive_idle();
            set_rd(0, 3);
            if (c == 0) begin
                wr_en   = 2'b11;
                wr_sel  = {4'd3, 4'd3};
                wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
            end
            push_exp(0, 32'h1234_5678, 1'b0);
            #1;
            wait_output();
            while (q.size() != 0) begin
                e = q.pop_front();
                got_d = rd_data[e.port*DW +: DW];
                got_p = rd_pend[e.port];
                checks++;
                if (got_d !== e.data || got_p !== e.pend) begin
                    errors++;
                    $display("[TB] FAIL dual_write c%0d: data=%h pend=%b, expected data=%h pend=%b",
                             c, got_d, got_p, e.data, e.pend);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_reg0();
        for (int c = 0; c < 2; c++) begin
            drive_idle();
            set_rd(1, 0);
            if (c == 0) begin
                wr_en   = 2'b11;
                wr_sel  = {4'd0, 4'd0};
                wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
                rsv_en  = 1'b1;
                rsv_sel = 4'd0;
            end
            push_exp(1, 32'h0, 1'b0);
            #1;
            checks++;
            if (rsv_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reg0_stall c%0d: stall=%b, expected 0", c, rsv_stall);
            end
            wait_output();
            while (q.size() != 0) begin
                e = q.pop_front();
                got_d = rd_data[e.port*DW +: DW];
                got_p = rd_pend[e.port];
                checks++;
                if (got_d !== e.data || got_p !== e.pend) begin
                    errors++;
                    $display("[TB] FAIL reg0_read c%0d: data=%h pend=%b, expected data=%h pend=%b",
                             c, got_d, got_p, e.data, e.pend);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_saturate();
        // Cycles 0-3 reserve r5, cycles 4-6 write it, cycle 7 idles.
        logic        exp_stall [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        exp_pend  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_data;
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            set_rd(2, 5);
            exp_data = 32'h0;
            if (c < 4) begin
                rsv_en  = 1'b1;
                rsv_sel = 4'd5;
            end else if (c < 7) begin
                wr_en         = 2'b01;
                wr_sel[3:0]   = 4'd5;
                wr_data[31:0] = 32'h5000_0000 + 32'(c - 4);
                exp_data      = 32'h5000_0000 + 32'(c - 4);
            end else begin
                exp_data = 32'h5000_0002;
            end
            push_exp(2, exp_data, exp_pend[c]);
            #1;
            checks++;
            if (rsv_stall !== exp_stall[c]) begin
                errors++;
                $display("[TB] FAIL saturate_stall c%0d: stall=%b, expected %b", c, rsv_stall, exp_stall[c]);
            end
            wait_output();
            while (q.size() != 0) begin
                e = q.pop_front();
                got_d = rd_data[e.port*DW +: DW];
                got_p = rd_pend[e.port];
                checks++;
                if (got_d !== e.data || got_p !== e.pend) begin
                    errors++;
                    $display("[TB] FAIL saturate_read c%0d: data=%h pend=%b, expected data=%h pend=%b",
                             c, got_d, got_p, e.data, e.pend);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_rsv_write_same();
        logic [31:0] exp_data [4] = '{32'h0, 32'h77, 32'h77, 32'h78};
        logic        exp_pend [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            set_rd(3, 7);
            if (c <= 1) begin
                rsv_en  = 1'b1;
                rsv_sel = 4'd7;
            end
            if (c == 1) begin
                wr_en         = 2'b01;
                wr_sel[3:0]   = 4'd7;
                wr_data[31:0] = 32'h77;
            end
            if (c == 3) begin
                wr_en          = 2'b10;
                wr_sel[7:4]    = 4'd7;
                wr_data[63:32] = 32'h78;
            end
            push_exp(3, exp_data[c], exp_pend[c]);
            #1;
            wait_output();
            while (q.size() != 0) begin
                e = q.pop_front();
                got_d = rd_data[e.port*DW +: DW];
                got_p = rd_pend[e.port];
                checks++;
                if (got_d !== e.data || got_p !== e.pend) begin
                    errors++;
                    $display("[TB] FAIL rsv_write_same c%0d: data=%h pend=%b, expected data=%h pend=%b",
                             c, got_d, got_p, e.data, e.pend);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3] = '{32'hA5, 32'hA6, 32'hA6};
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            set_rd(4, 2);
            if (c == 0) begin
                wr_en         = 2'b01;
                wr_sel[3:0]   = 4'd2;
                wr_data[31:0] = 32'hA5;
            end
            if (c == 1) begin
                wr_en   = 2'b11;
                wr_sel  = {4'd2, 4'd2};
                wr_data = {32'hA6, 32'h11};
            end
            push_exp(4, exp_data[c], 1'b0);
            #1;
            wait_output();
            while (q.size() != 0) begin
                e = q.pop_front();
                got_d = rd_data[e.port*DW +: DW];
                got_p = rd_pend[e.port];
                checks++;
                if (got_d !== e.data || got_p !== e.pend) begin
                    errors++;
                    $display("[TB] FAIL back_to_back c%0d: data=%h pend=%b, expected data=%h pend=%b",
                             c, got_d, got_p, e.data, e.pend);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_random();
        int fails_shown;
        fails_shown = 0;
        for (int c = 0; c < 10000; c++) begin
            drive_idle();
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 7));
            wr_en   = 2'($urandom_range(0, 3));
            wr_sel  = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            wr_data = {$urandom(), $urandom()};
            rsv_en  = ($urandom_range(0, 99) < 60);
            rsv_sel = 4'($urandom_range(0, 7));
            exp_s   = m_stall();
            push_model_all();
            #1;
            checks++;
            if (rsv_stall !== exp_s) begin
                errors++;
                if (fails_shown < 20) begin
                    fails_shown++;
                    $display("[TB] FAIL random_stall cyc%0d: stall=%b, expected %b", c, rsv_stall, exp_s);
                end
            end
            wait_output();
            while (q.size() != 0) begin
                e = q.pop_front();
                got_d = rd_data[e.port*DW +: DW];
                got_p = rd_pend[e.port];
                checks++;
                if (got_d !== e.data || got_p !== e.pend) begin
                    errors++;
                    if (fails_shown < 20) begin
                        fails_shown++;
                        $display("[TB] FAIL random_read cyc%0d port%0d: data=%h pend=%b, expected data=%h pend=%b",
                                 c, e.port, got_d, got_p, e.data, e.pend);
                    end
                end
            end
            finish_cycle();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_dual_write();
        test_reg0();
        test_saturate();
        test_rsv_write_same();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
